// File: rtl/mips_sched_pkg.sv
// Shared definitions for the in-order issue scheduler: instruction field
// positions, opcode values, FSM encoding and the source/destination decoder.
package mips_sched_pkg;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;

  typedef logic [5:0] opcode_t;

  localparam opcode_t OP_ADD   = 6'b000000;
  localparam opcode_t OP_SUB   = 6'b000001;
  localparam opcode_t OP_AND   = 6'b000010;
  localparam opcode_t OP_OR    = 6'b000011;
  localparam opcode_t OP_SLT   = 6'b000100;
  localparam opcode_t OP_MUL   = 6'b000101;
  localparam opcode_t OP_LW    = 6'b001000;
  localparam opcode_t OP_SW    = 6'b001001;
  localparam opcode_t OP_ADDI  = 6'b001010;
  localparam opcode_t OP_SUBI  = 6'b001011;
  localparam opcode_t OP_SLTI  = 6'b001100;
  localparam opcode_t OP_BNEQZ = 6'b001101;
  localparam opcode_t OP_BEQZ  = 6'b001110;
  localparam opcode_t OP_HLT   = 6'b111111;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_BR_WAIT = 2'd1,
    ST_HALT    = 2'd2
  } sched_state_e;

  // Register usage of one instruction. An unused source reads as R0, which
  // the scoreboard never marks busy, so no separate source enables are needed.
  typedef struct packed {
    logic [4:0] src_a;
    logic [4:0] src_b;
    logic       dst_en;
    logic [4:0] dst;
    logic       is_branch;
    logic       is_halt;
  } decode_t;

  // Only bits [31:11] carry opcode and register fields.
  function automatic decode_t decode_instr(input logic [31:11] hdr);
    decode_t d;
    d = '0;
    case (hdr[OPC_HI:OPC_LO])
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: begin
        d.src_a  = hdr[RS_HI:RS_LO];
        d.src_b  = hdr[RT_HI:RT_LO];
        d.dst_en = 1'b1;
        d.dst    = hdr[RD_HI:RD_LO];
      end
      OP_ADDI, OP_SUBI, OP_SLTI, OP_LW: begin
        d.src_a  = hdr[RS_HI:RS_LO];
        d.dst_en = 1'b1;
        d.dst    = hdr[RT_HI:RT_LO];
      end
      OP_SW: begin
        d.src_a = hdr[RS_HI:RS_LO];
        d.src_b = hdr[RT_HI:RT_LO];
      end
      OP_BNEQZ, OP_BEQZ: begin
        d.src_a     = hdr[RS_HI:RS_LO];
        d.is_branch = 1'b1;
      end
      OP_HLT:  d.is_halt = 1'b1;
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register write-back countdown. A register stays busy for WB_DIST
// cycles after a writer is accepted; R0 is hard-wired idle.
module reg_scoreboard
  import mips_sched_pkg::*;
#(
  parameter int unsigned WB_DIST = 3
) (
  input  logic       clk1,
  input  logic       rst_n,
  input  logic       set_en,
  input  logic [4:0] set_idx,
  input  logic [4:0] src_a_idx,
  input  logic [4:0] src_b_idx,
  output logic       hazard
);

  localparam logic [1:0] LOAD_VAL = 2'(WB_DIST);

  logic [1:0]  cnt [31:1];
  logic [31:0] busy;

  // Load on a new writer (wins over the decrement), otherwise count down to zero.
  always_ff @(posedge clk1) begin
    // NOTE: the counter array is reset explicitly; a stale nonzero count
    // after reset would stall the first dependent instruction.
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) cnt[i] <= 2'd0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (set_en && set_idx == 5'(i)) cnt[i] <= LOAD_VAL;
        else if (cnt[i] != 2'd0)         cnt[i] <= cnt[i] - 2'd1;
      end
    end
  end

  // Busy vector indexed directly by register number; bit 0 stays clear.
  always_comb begin
    // NOTE: default first so every bit is assigned on every pass (no latch).
    busy = '0;
    for (int i = 1; i < 32; i++) busy[i] = (cnt[i] != 2'd0);
  end

  assign hazard = busy[src_a_idx] | busy[src_b_idx];

endmodule

// File: rtl/hazard_scheduler.sv
// In-order issue stage: holds back RAW-dependent instructions until the
// producer has written back, waits for branch resolution, stops on HLT.
module hazard_scheduler
  import mips_sched_pkg::*;
#(
  parameter int unsigned WB_DIST     = 3,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk1,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [31:0]            in_instr,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [31:0]            out_instr,
  input  logic                   br_resolve,
  output logic                   halted,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [STALL_CNT_W-1:0] STALL_ONE = STALL_CNT_W'(1);

  sched_state_e state, state_next;
  decode_t      dec;
  logic         hazard;
  logic         accept;

  assign dec = decode_instr(in_instr[31:11]);

  reg_scoreboard #(.WB_DIST(WB_DIST)) u_scoreboard (
    .clk1      (clk1),
    .rst_n     (rst_n),
    .set_en    (accept && dec.dst_en),
    .set_idx   (dec.dst),
    .src_a_idx (dec.src_a),
    .src_b_idx (dec.src_b),
    .hazard    (hazard)
  );

  // rst_n gates ready so nothing is taken while reset is held.
  assign in_ready = rst_n && (state == ST_RUN) && !hazard;
  assign accept   = in_valid && in_ready;
  assign halted   = (state == ST_HALT);

  // State register.
  always_ff @(posedge clk1) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) state <= ST_RUN;
    else        state <= state_next;
  end

  // Next-state: branches park in BR_WAIT, HLT parks in HALT until reset.
  always_comb begin
    state_next = state;
    case (state)
      ST_RUN: begin
        if (accept && dec.is_branch)    state_next = ST_BR_WAIT;
        else if (accept && dec.is_halt) state_next = ST_HALT;
      end
      ST_BR_WAIT: if (br_resolve) state_next = ST_RUN;
      ST_HALT:    state_next = ST_HALT;
      default:    state_next = ST_RUN;
    endcase
  end

  // Issue register: the accepted word one cycle later, otherwise a zero bubble.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_instr <= '0;
    end else begin
      out_valid <= accept;
      out_instr <= accept ? in_instr : '0;
    end
  end

  // Saturating count of cycles a valid instruction was held back by a hazard.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (state == ST_RUN && in_valid && hazard && !(&stall_count)) begin
      stall_count <= stall_count + STALL_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Table-driven bench for hazard_scheduler; a second instance with a 2-bit
// stall counter shares the stimulus to exercise saturation.
module tb_hazard_scheduler;

  localparam logic [31:0] I_ADDI_R1 = 32'h28010032;
  localparam logic [31:0] I_ADDI_R2 = 32'h28020014;
  localparam logic [31:0] I_SUB_R3  = 32'h04221800;
  localparam logic [31:0] I_HLT     = 32'hFC000000;
  localparam logic [31:0] I_BEQZ_R0 = 32'h38000000;
  localparam logic [31:0] I_BNEQZ   = 32'h34000000;
  localparam logic [31:0] I_ADD_000 = 32'h00000000;
  localparam logic [31:0] I_ADD_R4  = 32'h00002000;
  localparam logic [31:0] I_ADD_R5  = 32'h00202800;

  logic        clk1 = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        br_resolve;

  logic        in_ready,  out_valid,  halted;
  logic [31:0] out_instr;
  logic [15:0] stall_count;

  logic        s_in_ready, s_out_valid, s_halted;
  logic [31:0] s_out_instr;
  logic [1:0]  s_stall_count;

  always #5 clk1 = ~clk1;

  hazard_scheduler #(.WB_DIST(3), .STALL_CNT_W(16)) dut (
    .clk1(clk1), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .out_valid(out_valid), .out_instr(out_instr),
    .br_resolve(br_resolve), .halted(halted), .stall_count(stall_count)
  );

  hazard_scheduler #(.WB_DIST(3), .STALL_CNT_W(2)) dut_sat (
    .clk1(clk1), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(s_in_ready), .out_valid(s_out_valid), .out_instr(s_out_instr),
    .br_resolve(br_resolve), .halted(s_halted), .stall_count(s_stall_count)
  );

  typedef struct {
    logic        rst;
    logic        vld;
    logic [31:0] instr;
    logic        br;
    logic        rdy;
    logic        hlt;
    int          stall;
  } vec_t;

  typedef struct {
    logic        v;
    logic [31:0] i;
  } exp_out_t;

  vec_t     vecs[$];
  exp_out_t sb[$];
  int       total = 0;
  int       bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic add(input logic rst, input logic vld, input logic [31:0] instr,
                     input logic br, input logic rdy, input logic hlt, input int stall);
    vec_t v;
    v.rst = rst; v.vld = vld; v.instr = instr; v.br = br;
    v.rdy = rdy; v.hlt = hlt; v.stall = stall;
    vecs.push_back(v);
  endtask

  task automatic check_out(input int k);
    exp_out_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("out_valid@%0d", k),   64'(out_valid),   64'(e.v));
      check($sformatf("out_instr@%0d", k),   64'(out_instr),   64'(e.i));
      check($sformatf("s_out_valid@%0d", k), 64'(s_out_valid), 64'(e.v));
      check($sformatf("s_out_instr@%0d", k), 64'(s_out_instr), 64'(e.i));
    end
  endtask

  initial begin
    exp_out_t e;
    int       sat;
    logic     acc;

    // Row fields: rst, vld, instr, br, expected in_ready, halted, stall_count.
    add(0, 0, I_ADD_000, 0, 0, 0, 0);   // reset state
    add(0, 1, I_ADDI_R1, 0, 0, 0, 0);   // ready held low during reset
    // RAW hazard: ADDI R1, ADDI R2, SUB R3,R1,R2
    add(1, 1, I_ADDI_R1, 0, 1, 0, 0);
    add(1, 1, I_ADDI_R2, 0, 1, 0, 0);
    add(1, 1, I_SUB_R3,  0, 0, 0, 0);
    add(1, 1, I_SUB_R3,  0, 0, 0, 1);
    add(1, 1, I_SUB_R3,  0, 0, 0, 2);
    add(1, 1, I_SUB_R3,  0, 1, 0, 3);
    // R0 as destination and source never stalls
    add(1, 1, I_ADD_000, 0, 1, 0, 3);
    add(1, 1, I_ADD_R4,  0, 1, 0, 3);
    // second dependency: pushes the 2-bit counter past its ceiling
    add(1, 1, I_ADDI_R1, 0, 1, 0, 3);
    add(1, 1, I_ADD_R5,  0, 0, 0, 3);
    add(1, 1, I_ADD_R5,  0, 0, 0, 4);
    add(1, 1, I_ADD_R5,  0, 0, 0, 5);
    add(1, 1, I_ADD_R5,  0, 1, 0, 6);
    add(1, 0, I_ADD_000, 0, 1, 0, 6);   // idle cycle -> bubble
    // branch: four BR_WAIT cycles, resolve on the fourth, not counted as stalls
    add(1, 1, I_BEQZ_R0, 0, 1, 0, 6);
    add(1, 1, I_ADD_R4,  0, 0, 0, 6);
    add(1, 1, I_ADD_R4,  0, 0, 0, 6);
    add(1, 1, I_ADD_R4,  0, 0, 0, 6);
    add(1, 1, I_ADD_R4,  1, 0, 0, 6);
    add(1, 1, I_ADD_R4,  0, 1, 0, 6);
    add(1, 1, I_ADD_R4,  1, 1, 0, 6);   // br_resolve in RUN ignored
    // mid-operation reset with R1 busy and state BR_WAIT
    add(1, 1, I_ADDI_R1, 0, 1, 0, 6);
    add(1, 1, I_BNEQZ,   0, 1, 0, 6);
    add(0, 1, I_SUB_R3,  0, 0, 0, 6);
    add(1, 1, I_SUB_R3,  0, 1, 0, 0);
    // independent stream ending in HLT
    add(1, 1, I_ADDI_R1, 0, 1, 0, 0);
    add(1, 1, I_ADDI_R2, 0, 1, 0, 0);
    add(1, 1, I_HLT,     0, 1, 0, 0);
    add(1, 1, I_ADD_R4,  0, 0, 1, 0);
    add(1, 1, I_ADD_R4,  1, 0, 1, 0);   // br_resolve in HALT ignored
    add(1, 1, I_ADD_R4,  0, 0, 1, 0);

    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; br_resolve = 1'b0;
    repeat (2) @(posedge clk1);

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk1);
      check_out(k);
      rst_n      = vecs[k].rst;
      in_valid   = vecs[k].vld;
      in_instr   = vecs[k].instr;
      br_resolve = vecs[k].br;
      #1;
      sat = (vecs[k].stall > 3) ? 3 : vecs[k].stall;
      check($sformatf("in_ready@%0d", k),      64'(in_ready),      64'(vecs[k].rdy));
      check($sformatf("halted@%0d", k),        64'(halted),        64'(vecs[k].hlt));
      check($sformatf("stall_count@%0d", k),   64'(stall_count),   64'(vecs[k].stall));
      check($sformatf("s_in_ready@%0d", k),    64'(s_in_ready),    64'(vecs[k].rdy));
      check($sformatf("s_stall_count@%0d", k), 64'(s_stall_count), 64'(sat));
      acc = vecs[k].rst && vecs[k].vld && vecs[k].rdy;
      e.v = acc;
      e.i = acc ? vecs[k].instr : 32'h0;
      sb.push_back(e);
    end

    @(negedge clk1);
    check_out(vecs.size());
    in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_scheduler.md
HAZARD_SCHEDULER -- requirements
Module: hazard_scheduler

Interface
REQ-001 SHALL have parameter WB_DIST, default 3, meaning the number of bubble cycles between a register-writing instruction and its first dependent instruction.
REQ-002 SHALL have parameter STALL_CNT_W, default 16, meaning the width of the stall counter.
REQ-003 SHALL have port clk1, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: the fetch stage presents an instruction.
REQ-006 SHALL have port in_instr, input, 32 bits: the fetched instruction word.
REQ-007 SHALL have port in_ready, output, 1 bit: combinational accept; a transfer occurs when in_valid && in_ready.
REQ-008 SHALL have port out_valid, output, 1 bit: out_instr is a real issued instruction, not a bubble.
REQ-009 SHALL have port out_instr, output, 32 bits: registered instruction to decode; 32'h00000000 when bubbling.
REQ-010 SHALL have port br_resolve, input, 1 bit: one-cycle pulse from the core when an issued branch resolves.
REQ-011 SHALL have port halted, output, 1 bit: HLT has been issued; sticky.
REQ-012 SHALL have port stall_count, output, STALL_CNT_W bits: count of hazard-stall cycles, saturating.

Function
REQ-013 SHALL decode opcode [31:26], rs [25:21], rt [20:16] and rd [15:11].
REQ-014 SHALL treat opcodes 000000–000101 (ADD, SUB, AND, OR, SLT, MUL) as sources rs/rt with destination rd.
REQ-015 SHALL treat ADDI 001010, SUBI 001011, SLTI 001100 and LW 001000 as source rs with destination rt.
REQ-016 SHALL treat SW 001001 as sources rs/rt with no destination.
REQ-017 SHALL treat BNEQZ 001101 and BEQZ 001110 as source rs with no destination.
REQ-018 SHALL treat HLT 111111 as having no sources and no destination.
REQ-019 SHALL treat unknown opcodes as having no sources and no destination.
REQ-020 SHALL keep a 2-bit countdown per register R1–R31; R0 is never tracked and never causes a stall.
REQ-021 SHALL load the destination counter with WB_DIST when a destination-writing instruction is accepted, overriding that cycle's decrement.
REQ-022 SHALL otherwise decrement each nonzero counter by one every cycle.
REQ-023 SHALL flag a hazard when any source register of in_instr has a nonzero counter.
REQ-024 SHALL drive in_ready = (state==RUN) && !hazard.
REQ-025 SHALL update out_instr/out_valid one cycle after acceptance (latency 1).
REQ-026 SHALL issue a NOP bubble (out_valid=0, out_instr=0) in every cycle without an acceptance.
REQ-027 SHALL implement states RUN, BR_WAIT and HALT:
- RUN→BR_WAIT on accepting a branch.
- BR_WAIT→RUN on br_resolve.
- RUN→HALT on accepting HLT.
- HALT is left only by reset.
- br_resolve in RUN or HALT is ignored.
REQ-028 SHALL assert halted from the cycle after HLT acceptance.
REQ-029 SHALL keep counters decrementing in BR_WAIT and HALT.
REQ-030 SHALL increment stall_count when state==RUN && in_valid && hazard, saturating at all-ones.
REQ-031 SHALL NOT count BR_WAIT cycles as stalls.
REQ-032 SHALL allow back-to-back acceptance of independent instructions every cycle.
REQ-033 SHALL NOT stall on WAW or WAR dependencies; the pipeline is in-order.

Reset
REQ-034 SHALL, while rst_n=0 at a clk1 edge, set state=RUN, all counters=0, out_valid=0, out_instr=0, halted=0 and stall_count=0.
REQ-035 SHALL drop any in-flight accepted instruction on reset mid-operation, with no output on the following cycle.
REQ-036 SHALL hold in_ready at 0 while rst_n=0.

Structure
REQ-037 SHALL place opcode constants, instruction field bit positions and the state encoding in shared package mips_sched_pkg.
REQ-038 SHALL implement the per-register counters as sub-module reg_scoreboard, with ports: set-enable, set-index, two source indices and a hazard output.

Verification
REQ-039 SHALL cover the hazard case:
- Stimulus: ADDI R1,R0,50 (28010032); ADDI R2,R0,20 (28020014); SUB R3,R1,R2 (04221800), offered back-to-back.
- Required response: ADDIs accepted in cycles 0 and 1; SUB accepted in cycle 5; 3 bubbles between the ADDI R2 and SUB issues; stall_count=3.
REQ-040 SHALL cover the independent case:
- Stimulus: ADDI R1 then ADDI R2 then HLT (FC000000).
- Required response: all accepted on consecutive cycles; halted=1 the cycle after HLT acceptance; in_ready=0 thereafter despite in_valid=1.
REQ-041 SHALL cover the branch case:
- Stimulus: BEQZ issued, with br_resolve pulsed 4 cycles later.
- Required response: in_ready=0 for those 4 cycles; bubbles issued; stall_count unchanged; acceptance resumes on the cycle after the pulse.
REQ-042 SHALL cover the R0 case:
- Stimulus: ADD R0,R0,R0 (00000000) followed by an instruction reading R0.
- Required response: no stall.
REQ-043 SHALL cover saturation:
- Stimulus: with STALL_CNT_W=2, force 5 hazard cycles.
- Required response: stall_count=3.
REQ-044 SHALL cover mid-operation reset:
- Stimulus: rst_n=0 for one cycle while counters are nonzero and state=BR_WAIT.
- Required response: next cycle state=RUN, a dependent instruction is accepted immediately, and all outputs are at reset values.
